// File: rtl/rca_sum_acc_if.sv
// rca_sum_acc_if: handshake bundle between the rca sum stream, the block accumulator and its consumer
// Parameters: IN_W sample width, BLOCK_LEN samples per block, ACC_W accumulator width.
// Signals:
//   start                  one-cycle block start request
//   in_valid/in_ready      sample handshake, in_sum carries the IN_W-bit adder sum
//   out_valid/out_ready    result handshake, out_acc/out_carries carry the block result
//   busy                   accumulator is not idle
//   out_ovf                sticky accumulator wrap flag (only with RCA_SUM_ACC_OVF_EN)
// Modports: master drives samples/start/out_ready, slave is the accumulator.
interface rca_sum_acc_if #(
    parameter int IN_W      = 9,
    parameter int BLOCK_LEN = 16,
    parameter int ACC_W     = 13
);
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    logic             start;
    logic             in_valid;
    logic [IN_W-1:0]  in_sum;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_carries;
    logic             busy;
`ifdef RCA_SUM_ACC_OVF_EN
    logic             out_ovf;
`endif
    modport master (
        output start, in_valid, in_sum, out_ready,
`ifdef RCA_SUM_ACC_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_acc, out_carries, busy
    );
    modport slave (
        input  start, in_valid, in_sum, out_ready,
`ifdef RCA_SUM_ACC_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_acc, out_carries, busy
    );
endinterface

// File: rtl/rca_sum_acc.sv
// rca_sum_acc: accumulates fixed-length blocks of rca sums and counts samples with the carry bit set
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears all state and discards a partial block
//   bus    rca_sum_acc_if.slave: start, in_valid/in_sum/in_ready, out_valid/out_ready,
//          out_acc, out_carries, busy (and out_ovf)
// Optional feature: define RCA_SUM_ACC_OVF_EN to add the sticky out_ovf wrap flag.
module rca_sum_acc #(
    parameter int IN_W      = 9,
    parameter int BLOCK_LEN = 16,
    parameter int ACC_W     = 13
) (
    input  logic         clk,
    input  logic         reset,
    rca_sum_acc_if.slave bus
);
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] car_q, car_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clr, take, last;

`ifdef RCA_SUM_ACC_OVF_EN
    logic             ovf_q, ovf_d;
    // One extra bit captures the carry out of the accumulator MSB.
    logic [ACC_W:0]   sum_w;
    assign sum_w = {1'b0, acc_q} + (ACC_W+1)'(bus.in_sum);
`else
    logic [ACC_W-1:0] sum_w;
    assign sum_w = acc_q + ACC_W'(bus.in_sum);
`endif

    assign clr  = state_q == IDLE && bus.start;
    assign take = state_q == ACCUM && bus.in_valid;
    assign last = cnt_q == CNT_W'(BLOCK_LEN - 1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        car_d   = car_q;
        cnt_d   = cnt_q;
`ifdef RCA_SUM_ACC_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            car_d   = '0;
            cnt_d   = '0;
`ifdef RCA_SUM_ACC_OVF_EN
            ovf_d   = 1'b0;
`endif
        end else if (take) begin
            // The final sample's update and the move to HOLD share one edge.
            state_d = last ? HOLD : ACCUM;
            acc_d   = sum_w[ACC_W-1:0];
            car_d   = car_q + CNT_W'(bus.in_sum[IN_W-1]);
            cnt_d   = cnt_q + CNT_W'(1);
`ifdef RCA_SUM_ACC_OVF_EN
            ovf_d   = ovf_q | sum_w[ACC_W];
`endif
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            car_q   <= '0;
            cnt_q   <= '0;
`ifdef RCA_SUM_ACC_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            car_q   <= car_d;
            cnt_q   <= cnt_d;
`ifdef RCA_SUM_ACC_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready    = state_q == ACCUM;
    assign bus.out_valid   = state_q == HOLD;
    assign bus.busy        = state_q != IDLE;
    assign bus.out_acc     = acc_q;
    assign bus.out_carries = car_q;
`ifdef RCA_SUM_ACC_OVF_EN
    assign bus.out_ovf     = ovf_q;
`endif
endmodule

// File: doc/rca_sum_acc.md
# rca_sum_acc

Block-sum accumulator that sits directly downstream of the 8-bit ripple-carry adder `rca`. It consumes the adder's 9-bit `sum` one sample at a time over a valid/ready handshake and accumulates a fixed-length block of `BLOCK_LEN` samples. It also counts how many samples had the carry bit (`sum[8]`) set, then presents the block total on an output handshake. It lets the adder's result stream be checked and reduced in hardware instead of by waveform inspection.

## Interface

Parameters:
- `IN_W`, 9: input sample width; matches `rca` sum width; MSB is the adder carry-out.
- `BLOCK_LEN`, 16: samples per block, ≥2.
- `ACC_W`, 13: accumulator width; default is exactly wide enough for `BLOCK_LEN*(2^IN_W-1)`.
- `CNT_W` is a localparam, `$clog2(BLOCK_LEN+1)`: width of the sample and carry counters.

Ports:
- `clk`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a block; honoured only in IDLE.
- `in_valid`  in  1  `in_sum` is valid.
- `in_sum`  in  IN_W  adder sum sample.
- `in_ready`  out  1  block accepts a sample; high only in ACCUM.
- `out_valid`  out  1  block result valid; high only in HOLD.
- `out_ready`  in  1  consumer takes the result.
- `out_acc`  out  ACC_W  sum of the block's samples, modulo 2^ACC_W.
- `out_carries`  out  CNT_W  number of block samples with `in_sum[IN_W-1]==1`.
- `busy`  out  1  state != IDLE.

## Operation

- FSM states: IDLE, ACCUM, HOLD. Reset state is IDLE.
- IDLE:
  - `start=1` → ACCUM at the next edge.
  - On that same edge, the accumulator, carry counter and sample counter are cleared to 0.
  - `out_acc`/`out_carries` keep their last values until the clear edge.
- ACCUM:
  - A sample is accepted on an edge where `in_valid && in_ready`.
  - On acceptance, add zero-extended `in_sum` to the accumulator.
  - On acceptance, increment the carry counter if the MSB is set.
  - On acceptance, increment the sample counter.
  - On acceptance of sample number `BLOCK_LEN`, the final update is applied and the state goes to HOLD on the same edge.
  - `in_valid` gaps are permitted; the state simply waits.
- HOLD:
  - `out_valid=1`, and `out_acc`/`out_carries` are stable.
  - `out_valid && out_ready` → IDLE at the next edge.
- `start` outside IDLE is ignored; it is not queued.
- Arithmetic: the accumulator is unsigned and wraps modulo 2^ACC_W.
- `out_acc` and `out_carries` are the accumulator and carry-counter registers themselves; they have no separate output register.
- Reset at any time:
  - all registers go to 0 and the state goes to IDLE, asynchronously;
  - any partial block is discarded.

## Timing

- Reset values:
  - `in_ready=0`, `out_valid=0`, `busy=0`;
  - `out_acc=0`, `out_carries=0`;
  - overflow flag = 0 (when compiled in).
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- `start` at edge N → `in_ready=1` and `busy=1` from edge N+1.
- Last sample accepted at edge M → `in_ready=0` and `out_valid=1` from edge M+1. There is no extra latency.
- Handshake at edge H → `out_valid=0` and `busy=0` from edge H+1.
- Best-case block time: 1 cycle (start) + `BLOCK_LEN` cycles + 1 cycle (result taken) = `BLOCK_LEN+2` cycles from `start` back to IDLE.
- Back-to-back blocks: `start` may be asserted on the first IDLE cycle.

## Configuration

- `RCA_SUM_ACC_OVF_EN`, when defined:
  - adds output port `out_ovf` (1 bit);
  - `out_ovf` is a sticky flag, set when any accumulate carries out of bit ACC_W-1;
  - it is cleared at the block-start edge and by reset;
  - it is valid alongside `out_acc` in HOLD.
- When not defined: the port is absent, and wrap-around is silent.

## Test plan

- Reset:
  - check all outputs are 0 and the state is IDLE during reset;
  - drive `in_valid=1` with `reset` low → `in_ready` stays 0 and nothing is accumulated.
- Basic block: `start`, then 16 back-to-back samples of 9'd1 → `out_valid` rises the cycle after the 16th accept, with `out_acc=16` and `out_carries=0`.
- Full scale: 16 samples of 9'h1FF (255+256) → `out_acc=8176` and `out_carries=16`.
- Flow control:
  - drop `in_valid` for 3 cycles after every second sample, then hold `out_ready=0` for 5 cycles in HOLD → outputs stay stable;
  - a `start` pulse during HOLD is ignored;
  - result of samples 0..15 is `out_acc=120`, and the next block starts only on a later `start`.
- Reset mid-block: assert `reset` after 7 accepted samples → immediate IDLE with all outputs 0; a new block of 16×9'd2 gives `out_acc=32`.
- Overflow (`RCA_SUM_ACC_OVF_EN`, `ACC_W=10`): 16×9'h1FF → `out_acc=1008` and `out_ovf=1`; the next block of 16×9'd1 gives `out_ovf=0` and `out_acc=16`.
